// File: rtl/tcb_gpio_debounce.sv
// Per-bit GPIO input debounce filter with shared sampling prescaler.
// Define TCB_GPIO_DEBOUNCE_EVENT_EN to build the rise/fall event pulse registers.
module tcb_gpio_debounce #(
  parameter int unsigned GW = 32,
  parameter int unsigned PW = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_ena,
  input  logic [PW-1:0] cfg_div,
  input  logic [CW-1:0] cfg_thr,
  input  logic [GW-1:0] raw_i,
  output logic [GW-1:0] deb_o,
  output logic [GW-1:0] evt_r,
  output logic [GW-1:0] evt_f
);

  localparam logic [PW-1:0] DIV_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] DIV_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [PW-1:0]         div_cnt;
  logic                  tick;
  logic [GW-1:0][CW-1:0] cnt;
  logic [GW-1:0][CW-1:0] cnt_nxt;
  logic [GW-1:0]         deb_nxt;

  assign tick = cfg_ena && (div_cnt == cfg_div);

  // Shared prescaler; a lowered divisor lets the counter wrap through its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= DIV_ZERO;
    end else if (!cfg_ena) begin
      div_cnt <= DIV_ZERO;
    end else if (tick) begin
      div_cnt <= DIV_ZERO;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Next filtered level and stability count for every bit.
  always_comb begin
    deb_nxt = deb_o;
    cnt_nxt = cnt;
    for (int n = 0; n < GW; n++) begin
      if (!cfg_ena) begin
        deb_nxt[n] = raw_i[n];
        cnt_nxt[n] = CNT_ZERO;
      end else if (raw_i[n] == deb_o[n]) begin
        // any agreement, tick or not, discards the partial count
        cnt_nxt[n] = CNT_ZERO;
      end else if (tick) begin
        if (cnt[n] >= cfg_thr) begin
          deb_nxt[n] = raw_i[n];
          cnt_nxt[n] = CNT_ZERO;
        end else begin
          cnt_nxt[n] = cnt[n] + CNT_ONE;
        end
      end else begin
        cnt_nxt[n] = cnt[n];
      end
    end
  end

  // Filtered output and per-bit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_o <= {GW{1'b0}};
      cnt   <= {GW{CNT_ZERO}};
    end else begin
      deb_o <= deb_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef TCB_GPIO_DEBOUNCE_EVENT_EN
  // Event pulses land in the same cycle as the deb_o update they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_r <= {GW{1'b0}};
      evt_f <= {GW{1'b0}};
    end else begin
      evt_r <= deb_nxt & ~deb_o;
      evt_f <= ~deb_nxt & deb_o;
    end
  end
`else
  assign evt_r = {GW{1'b0}};
  assign evt_f = {GW{1'b0}};
`endif

endmodule
